// File: rtl/regfile_tagged.sv
// Tagged integer register file: per-register busy/ROB-tag scoreboard, commit bypass.
// Optional debug read port (dbg_addr/dbg_data) enabled by defining REGFILE_DBG_EN.
module regfile_tagged #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rename_en,
  input  logic [AW-1:0]    rename_addr,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic             commit_en,
  input  logic [AW-1:0]    commit_addr,
  input  logic [XLEN-1:0]  commit_data,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             rd_en1,
  input  logic [AW-1:0]    rd_addr1,
  output logic [XLEN-1:0]  rd_data1,
  output logic             rd_busy1,
  output logic [TAG_W-1:0] rd_tag1,
  input  logic             rd_en2,
  input  logic [AW-1:0]    rd_addr2,
  output logic [XLEN-1:0]  rd_data2,
  output logic             rd_busy2,
  output logic [TAG_W-1:0] rd_tag2
`ifdef REGFILE_DBG_EN
  ,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data
`endif
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  logic cmt_ok;
  logic cmt_hit;
  logic ren_ok;

  assign cmt_ok  = commit_en && (commit_addr != '0);
  assign cmt_hit = busy_q[commit_addr] &&
                   (tag_q[commit_addr] == commit_tag);
  assign ren_ok  = rename_en && (rename_addr != '0);

  // Rename is applied after commit so it wins on the same register.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (cmt_ok) begin
      regs_d[commit_addr] = commit_data;
      if (cmt_hit) busy_d[commit_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (ren_ok) begin
      busy_d[rename_addr] = 1'b1;
      tag_d[rename_addr]  = rename_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Returns {busy, tag, data}; commit data is forwarded even on a tag miss.
  function automatic logic [XLEN+TAG_W:0] rd_port(
    input logic          en,
    input logic [AW-1:0] a
  );
    logic [XLEN-1:0]  d;
    logic [TAG_W-1:0] t;
    logic             b;
    d = '0;
    t = '0;
    b = 1'b0;
    if (en && !rst && (a != '0)) begin
      d = regs_q[a];
      t = tag_q[a];
      b = busy_q[a];
      if (commit_en && (commit_addr == a)) begin
        d = commit_data;
        if (busy_q[a] && (tag_q[a] == commit_tag)) b = 1'b0;
      end
    end
    return {b, t, d};
  endfunction

  assign {rd_busy1, rd_tag1, rd_data1} = rd_port(rd_en1, rd_addr1);
  assign {rd_busy2, rd_tag2, rd_data2} = rd_port(rd_en2, rd_addr2);

`ifdef REGFILE_DBG_EN
  assign dbg_data = (rst || (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];
`else
  // No debug port in this build.
`endif

endmodule

// File: tb/tb_regfile_tagged.sv
// Bench for regfile_tagged: directed literal checks plus random traffic
// compared every cycle against an array-based reference model.
module tb_regfile_tagged;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        rename_en;
  logic [4:0]  rename_addr;
  logic [3:0]  rename_tag;
  logic        commit_en;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;
  logic        rd_en1, rd_en2;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic [3:0]  rd_tag1, rd_tag2;

  regfile_tagged dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rename_en(rename_en), .rename_addr(rename_addr),
    .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_busy1(rd_busy1), .rd_tag1(rd_tag1),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
    .rd_busy2(rd_busy2), .rd_tag2(rd_tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  // Reference model state update.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
        m_tag[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (commit_en && commit_addr == 5'(i))
          m_regs[i] <= commit_data;
        m_busy[i] <= flush ? 1'b0 :
          (rename_en && rename_addr == 5'(i)) ? 1'b1 :
          (commit_en && commit_addr == 5'(i) && m_busy[i] &&
           m_tag[i] == commit_tag) ? 1'b0 : m_busy[i];
        m_tag[i] <= (!flush && rename_en && rename_addr == 5'(i)) ?
          rename_tag : m_tag[i];
      end
    end
  end

  task automatic exp_rd(
    input  logic        en,
    input  logic [4:0]  a,
    output logic [31:0] d,
    output logic        b,
    output logic [3:0]  t,
    output logic        z
  );
    z = !en || rst || a == 5'd0;
    d = '0;
    b = 1'b0;
    t = '0;
    if (!z) begin
      d = m_regs[a];
      b = m_busy[a];
      t = m_tag[a];
      if (commit_en && commit_addr == a) begin
        d = commit_data;
        if (m_busy[a] && m_tag[a] == commit_tag) b = 1'b0;
      end
    end
  endtask

  logic [31:0] e_d;
  logic        e_b, e_z;
  logic [3:0]  e_t;

  // Per-cycle compare against the model; tag only matters when busy or forced zero.
  always @(negedge clk) begin
    if (chk_on) begin
      exp_rd(rd_en1, rd_addr1, e_d, e_b, e_t, e_z);
      checks++;
      if (rd_data1 !== e_d || rd_busy1 !== e_b ||
          ((e_b || e_z) && rd_tag1 !== e_t)) begin
        errors++;
        $display("FAIL port1 a=%0d got d=%h b=%b t=%h exp d=%h b=%b t=%h",
                 rd_addr1, rd_data1, rd_busy1, rd_tag1, e_d, e_b, e_t);
      end
      exp_rd(rd_en2, rd_addr2, e_d, e_b, e_t, e_z);
      checks++;
      if (rd_data2 !== e_d || rd_busy2 !== e_b ||
          ((e_b || e_z) && rd_tag2 !== e_t)) begin
        errors++;
        $display("FAIL port2 a=%0d got d=%h b=%b t=%h exp d=%h b=%b t=%h",
                 rd_addr2, rd_data2, rd_busy2, rd_tag2, e_d, e_b, e_t);
      end
    end
  end

  task automatic lit(
    input string        nm,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    flush     = 1'b0;
    rename_en = 1'b0;
    commit_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rename_addr = '0; rename_tag = '0;
    commit_addr = '0; commit_data = '0; commit_tag = '0;
    rd_en1 = 1'b1; rd_en2 = 1'b1;
    rd_addr1 = 5'd5; rd_addr2 = 5'd0;
    chk_on = 1'b1;
    step();
    step();
    lit("rst_gate", {rd_data1, rd_busy1, rd_tag1}, 0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      lit($sformatf("reset_x%0d", i),
          {rd_data1, rd_busy1, rd_tag1, rd_data2, rd_busy2, rd_tag2}, 0);
    end
    step();

    rename_en = 1'b1; rename_addr = 5'd5; rename_tag = 4'd3;
    step();
    idle();
    rd_addr1 = 5'd5;
    #1 lit("x5_busy", {rd_busy1, rd_tag1}, {1'b1, 4'd3});
    commit_en = 1'b1; commit_addr = 5'd5;
    commit_data = 32'hDEADBEEF; commit_tag = 4'd3;
    #1 lit("x5_bypass", {rd_data1, rd_busy1}, {32'hDEADBEEF, 1'b0});
    step();
    idle();
    #1 lit("x5_stored", {rd_data1, rd_busy1}, {32'hDEADBEEF, 1'b0});

    rename_en = 1'b1; rename_addr = 5'd7; rename_tag = 4'd2;
    step();
    rename_tag = 4'd9;
    step();
    idle();
    commit_en = 1'b1; commit_addr = 5'd7;
    commit_data = 32'h11; commit_tag = 4'd2;
    rd_addr1 = 5'd7;
    #1 lit("x7_stale", {rd_data1, rd_busy1, rd_tag1},
           {32'h11, 1'b1, 4'd9});
    step();
    commit_data = 32'h22; commit_tag = 4'd9;
    #1 lit("x7_bypass", {rd_data1, rd_busy1}, {32'h22, 1'b0});
    step();
    idle();
    #1 lit("x7_stored", {rd_data1, rd_busy1}, {32'h22, 1'b0});

    commit_en = 1'b1; commit_addr = 5'd4;
    commit_data = 32'h55; commit_tag = 4'd0;
    step();
    idle();
    rename_en = 1'b1; rename_addr = 5'd4; rename_tag = 4'd6;
    rd_addr1 = 5'd4;
    #1 lit("x4_same_cyc", {rd_data1, rd_busy1}, {32'h55, 1'b0});
    step();
    idle();
    #1 lit("x4_next", {rd_data1, rd_busy1, rd_tag1},
           {32'h55, 1'b1, 4'd6});

    for (int i = 1; i <= 3; i++) begin
      rename_en = 1'b1; rename_addr = 5'(i); rename_tag = 4'(i);
      step();
    end
    flush = 1'b1;
    rename_en = 1'b1; rename_addr = 5'd8; rename_tag = 4'd4;
    rd_addr1 = 5'd1; rd_addr2 = 5'd3;
    #1 lit("flush_not_vis", {rd_busy1, rd_busy2}, 2'b11);
    step();
    idle();
    rd_addr1 = 5'd1; rd_addr2 = 5'd8;
    #1 lit("flush_x1_x8", {rd_busy1, rd_busy2}, 0);
    rd_addr1 = 5'd2; rd_addr2 = 5'd3;
    #1 lit("flush_x2_x3", {rd_busy1, rd_busy2}, 0);

    commit_en = 1'b1; commit_addr = 5'd0;
    commit_data = 32'hFFFFFFFF; commit_tag = 4'd5;
    rename_en = 1'b1; rename_addr = 5'd0; rename_tag = 4'd5;
    rd_addr1 = 5'd0;
    #1 lit("x0_same", {rd_data1, rd_busy1, rd_tag1}, 0);
    step();
    idle();
    #1 lit("x0_after", {rd_data1, rd_busy1, rd_tag1}, 0);

    rename_en = 1'b1; rename_addr = 5'd9; rename_tag = 4'd7;
    step();
    idle();
    rst = 1'b1;
    rd_addr1 = 5'd5;
    #1 lit("rst_mid_gate", {rd_data1, rd_busy1}, 0);
    step();
    rst = 1'b0;
    rd_addr1 = 5'd5; rd_addr2 = 5'd9;
    #1 lit("rst_mid_state",
           {rd_data1, rd_busy1, rd_tag1, rd_data2, rd_busy2, rd_tag2}, 0);

    for (int c = 0; c < 3000; c++) begin
      step();
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      rename_en   = 1'($urandom);
      rename_addr = 5'($urandom_range(0, 9));
      rename_tag  = 4'($urandom);
      commit_en   = 1'($urandom);
      commit_addr = 5'($urandom_range(0, 9));
      commit_data = $urandom;
      commit_tag  = ($urandom_range(0, 3) != 0) ?
                    m_tag[commit_addr] : 4'($urandom);
      rd_en1   = ($urandom_range(0, 7) != 0);
      rd_en2   = ($urandom_range(0, 7) != 0);
      rd_addr1 = ($urandom_range(0, 2) == 0) ?
                 commit_addr : 5'($urandom_range(0, 9));
      rd_addr2 = ($urandom_range(0, 2) == 0) ?
                 commit_addr : 5'($urandom_range(0, 31));
    end
    step();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
